// File: rtl/vga_char_feeder_if.sv
// vga_char_feeder_if: CPU write port and display strobe port of the character feeder.
//   wr_data    [6:0]  ASCII character from the CPU
//   wr_stb            1-cycle write qualifier for wr_data
//   ready             1 when the FIFO is not full
//   overflow          1-cycle pulse when an accepted character was dropped
//   fifo_level        number of entries currently stored
//   out_char   [6:0]  character presented to the display
//   out_stb           display strobe
// Modports: master = CPU/display side (testbench), slave = feeder.
interface vga_char_feeder_if #(
    parameter int DEPTH = 16
);
    logic [6:0]             wr_data;
    logic                   wr_stb;
    logic                   ready;
    logic                   overflow;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [6:0]             out_char;
    logic                   out_stb;

    modport master (
        output wr_data, wr_stb,
        input  ready, overflow, fifo_level, out_char, out_stb
    );

    modport slave (
        input  wr_data, wr_stb,
        output ready, overflow, fifo_level, out_char, out_stb
    );
endinterface

// File: rtl/vga_char_feeder.sv
// vga_char_feeder: upstream stage of the 40x24 VGA text display. Filters and upper-case folds
// CPU characters, buffers them in a FIFO and replays each one as a clean strobe pulse
// (out_char held stable, out_stb high STB_HIGH cycles then low STB_LOW cycles).
// Ports:
//   clk25   pixel/system clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     vga_char_feeder_if.slave (wr_data, wr_stb, ready, overflow, fifo_level,
//           out_char, out_stb)
// Optional feature: define VGA_CHAR_FEEDER_CR_PAD_EN to store 0x0D and expand it into
// space pulses up to the end of the current COLS-wide row.
module vga_char_feeder #(
    parameter int DEPTH    = 16,
    parameter int STB_HIGH = 2,
    parameter int STB_LOW  = 2
`ifdef VGA_CHAR_FEEDER_CR_PAD_EN
    ,
    parameter int COLS     = 40
`endif
) (
    input logic              clk25,
    input logic              rst_n,
    vga_char_feeder_if.slave bus
);
    localparam int AW      = $clog2(DEPTH);
    localparam int LW      = AW + 1;
    localparam int CNT_MAX = (STB_HIGH > STB_LOW) ? STB_HIGH : STB_LOW;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StHigh, StLow} state_t;

    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          ready_q, overflow_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [6:0]    out_char_q;
    logic          out_stb_q;
    logic          in_valid, push, drop, pop;
    logic [6:0]    in_char, head;

`ifdef VGA_CHAR_FEEDER_CR_PAD_EN
    localparam int COLW = $clog2(COLS);
    logic [COLW-1:0] column_q;
    logic            pad_q;
    logic            pad_hold;
    // Still padding a CR: keep emitting spaces until the column wraps back to 0.
    assign pad_hold = pad_q && (column_q != '0);
`endif

    assign head = mem[rd_ptr_q];

    always_comb begin
        in_valid = 1'b0;
        in_char  = bus.wr_data;
        if (bus.wr_stb) begin
            if (bus.wr_data >= 7'h20 && bus.wr_data <= 7'h5F) begin
                in_valid = 1'b1;
            end else if (bus.wr_data >= 7'h60) begin
                in_valid = 1'b1;
                in_char  = bus.wr_data - 7'h20;
            end
`ifdef VGA_CHAR_FEEDER_CR_PAD_EN
            else if (bus.wr_data == 7'h0D) begin
                in_valid = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        pop = (state_q == StIdle) && (level_q != '0);
`ifdef VGA_CHAR_FEEDER_CR_PAD_EN
        pop = pop && !pad_hold;
`endif
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        push    = in_valid && ((level_q != LW'(DEPTH)) || pop);
        drop    = in_valid && !push;
        level_d = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk25) begin
        if (push) mem[wr_ptr_q] <= in_char;
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q    <= level_d;
            ready_q    <= (level_d != LW'(DEPTH));
            overflow_q <= drop;
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            out_char_q <= 7'h20;
            out_stb_q  <= 1'b0;
`ifdef VGA_CHAR_FEEDER_CR_PAD_EN
            column_q   <= '0;
            pad_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
`ifdef VGA_CHAR_FEEDER_CR_PAD_EN
                    // out_char already holds 0x20 while padding.
                    if (pad_hold) begin
                        state_q <= StLoad;
                    end else begin
                        pad_q <= pop && (head == 7'h0D);
                        if (pop) begin
                            out_char_q <= (head == 7'h0D) ? 7'h20 : head;
                            state_q    <= StLoad;
                        end
                    end
`else
                    if (pop) begin
                        out_char_q <= head;
                        state_q    <= StLoad;
                    end
`endif
                end
                StLoad: begin
                    out_stb_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= StHigh;
`ifdef VGA_CHAR_FEEDER_CR_PAD_EN
                    column_q  <= (column_q == COLW'(COLS - 1)) ? '0 : column_q + COLW'(1);
`endif
                end
                StHigh: begin
                    if (cnt_q == CW'(STB_HIGH - 1)) begin
                        out_stb_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= StLow;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StLow: begin
                    if (cnt_q == CW'(STB_LOW - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ready      = ready_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_level = level_q;
    assign bus.out_char   = out_char_q;
    assign bus.out_stb    = out_stb_q;
endmodule

// File: tb/tb_vga_char_feeder.sv
`timescale 1ns/1ps
module tb_vga_char_feeder;
    localparam int H    = 2;
    localparam int L    = 2;
    localparam int COLS = 40;

    logic clk25 = 1'b0;
    logic rst_n = 1'b0;

    vga_char_feeder_if #(.DEPTH(16)) bus ();

    vga_char_feeder dut (
        .clk25 (clk25),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #20 clk25 = ~clk25;

    int         errors = 0;
    int         checks = 0;
    logic [6:0] emitted[$];
    logic [6:0] exp_q[$];
    int         model_col = 0;
    int         ovf_cnt = 0;

    // Pulse monitor: records each rising strobe and checks pulse shape.
    logic       prev_stb = 1'b0;
    int         high_len = 0;
    int         since_rise = 1000;
    logic [6:0] cap = 7'h00;

    always @(negedge clk25) begin
        if (!rst_n) begin
            prev_stb   = 1'b0;
            high_len   = 0;
            since_rise = 1000;
        end else begin
            if (bus.overflow === 1'b1) ovf_cnt++;
            since_rise++;
            if (bus.out_stb === 1'b1 && !prev_stb) begin
                checks++;
                if (since_rise < 2 + H + L) begin
                    errors++;
                    $display("FAIL rise_spacing: got %0d cycles, need >= %0d", since_rise, 2 + H + L);
                end
                emitted.push_back(bus.out_char);
                cap        = bus.out_char;
                high_len   = 1;
                since_rise = 0;
            end else if (bus.out_stb === 1'b1) begin
                high_len++;
                checks++;
                if (bus.out_char !== cap) begin
                    errors++;
                    $display("FAIL char_stable: got %0h expected %0h", bus.out_char, cap);
                end
            end else if (prev_stb) begin
                checks++;
                if (high_len != H) begin
                    errors++;
                    $display("FAIL high_len: got %0d expected %0d", high_len, H);
                end
            end
            prev_stb = (bus.out_stb === 1'b1);
        end
    end

    // Reference model: expected display pulses for one CPU write.
    task automatic expand(input logic [6:0] c);
        if (c >= 7'h20 && c <= 7'h5F) begin
            exp_q.push_back(c);
            model_col = (model_col + 1) % COLS;
        end else if (c >= 7'h60) begin
            exp_q.push_back(c - 7'h20);
            model_col = (model_col + 1) % COLS;
        end
`ifdef VGA_CHAR_FEEDER_CR_PAD_EN
        else if (c == 7'h0D) begin
            repeat (COLS - model_col) exp_q.push_back(7'h20);
            model_col = 0;
        end
`endif
    endtask

    task automatic do_reset();
        @(negedge clk25);
        #2 rst_n = 1'b0;
        bus.wr_stb = 1'b0;
        @(negedge clk25);
        #2 rst_n = 1'b1;
        model_col = 0;
        exp_q.delete();
        emitted.delete();
        ovf_cnt = 0;
    endtask

    task automatic wait_emitted(input int n, output bit timed_out);
        int budget;
        budget = n * 8 + 100;
        while (emitted.size() < n && budget > 0) begin
            @(negedge clk25);
            budget--;
        end
        timed_out = (emitted.size() < n);
        repeat (30) @(negedge clk25);
    endtask

    task automatic test_reset();
        int budget;
        rst_n = 1'b0;
        bus.wr_stb = 1'b0;
        bus.wr_data = 7'h00;
        repeat (2) @(negedge clk25);
        checks += 5;
        if (bus.fifo_level !== 5'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", bus.fifo_level); end
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", bus.ready); end
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", bus.overflow); end
        if (bus.out_char !== 7'h20) begin errors++; $display("FAIL rst_char: got %0h expected 20", bus.out_char); end
        if (bus.out_stb !== 1'b0) begin errors++; $display("FAIL rst_stb: got %b expected 0", bus.out_stb); end
        #2 rst_n = 1'b1;
        // Reset in the middle of a strobe pulse.
        @(negedge clk25);
        bus.wr_data = 7'h41;
        bus.wr_stb  = 1'b1;
        @(negedge clk25);
        bus.wr_stb = 1'b0;
        budget = 20;
        while (bus.out_stb !== 1'b1 && budget > 0) begin
            @(negedge clk25);
            budget--;
        end
        checks++;
        if (bus.out_stb !== 1'b1) begin errors++; $display("FAIL mid_pulse_wait: got %b expected 1", bus.out_stb); end
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (bus.out_stb !== 1'b0) begin errors++; $display("FAIL midrst_stb: got %b expected 0", bus.out_stb); end
        if (bus.fifo_level !== 5'd0) begin errors++; $display("FAIL midrst_level: got %0d expected 0", bus.fifo_level); end
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", bus.ready); end
        if (bus.out_char !== 7'h20) begin errors++; $display("FAIL midrst_char: got %0h expected 20", bus.out_char); end
        @(negedge clk25);
        #2 rst_n = 1'b1;
        model_col = 0;
        exp_q.delete();
        emitted.delete();
        ovf_cnt = 0;
        repeat (30) @(negedge clk25);
        checks++;
        if (emitted.size() != 0) begin errors++; $display("FAIL post_rst_idle: got %0d pulses expected 0", emitted.size()); end
    endtask

    task automatic test_single();
        bit to;
        emitted.delete();
        exp_q.delete();
        @(negedge clk25);
        bus.wr_data = 7'h41;
        bus.wr_stb  = 1'b1;
        expand(7'h41);
        @(negedge clk25);
        bus.wr_stb = 1'b0;
        checks++;
        if (bus.fifo_level !== 5'd1) begin errors++; $display("FAIL single_level_e0: got %0d expected 1", bus.fifo_level); end
        @(negedge clk25);
        checks += 3;
        if (bus.out_char !== 7'h41) begin errors++; $display("FAIL single_char_e1: got %0h expected 41", bus.out_char); end
        if (bus.fifo_level !== 5'd0) begin errors++; $display("FAIL single_level_e1: got %0d expected 0", bus.fifo_level); end
        if (bus.out_stb !== 1'b0) begin errors++; $display("FAIL single_stb_e1: got %b expected 0", bus.out_stb); end
        for (int i = 0; i < H + L; i++) begin
            @(negedge clk25);
            checks++;
            if (bus.out_stb !== (i < H)) begin
                errors++;
                $display("FAIL single_stb_shape: cycle %0d got %b expected %b", i, bus.out_stb, (i < H));
            end
        end
        wait_emitted(exp_q.size(), to);
        checks += 2;
        if (emitted.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", emitted.size()); end
        else if (emitted[0] !== exp_q[0]) begin errors++; $display("FAIL single_emit: got %0h expected %0h", emitted[0], exp_q[0]); end
        if (to) begin errors++; $display("FAIL single_timeout: got %0d pulses expected 1", emitted.size()); end
    endtask

    task automatic test_filter();
        logic [6:0] seq[3];
        bit to;
        seq = '{7'h61, 7'h07, 7'h7B};
        emitted.delete();
        exp_q.delete();
        ovf_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk25);
            bus.wr_data = seq[i];
            bus.wr_stb  = 1'b1;
            expand(seq[i]);
        end
        @(negedge clk25);
        bus.wr_stb = 1'b0;
        wait_emitted(exp_q.size(), to);
        checks += 3;
        if (to) begin errors++; $display("FAIL filter_timeout: got %0d pulses expected %0d", emitted.size(), exp_q.size()); end
        if (emitted.size() != exp_q.size()) begin
            errors++;
            $display("FAIL filter_count: got %0d expected %0d", emitted.size(), exp_q.size());
        end
        if (ovf_cnt != 0) begin errors++; $display("FAIL filter_ovf: got %0d expected 0", ovf_cnt); end
        for (int i = 0; i < exp_q.size() && i < emitted.size(); i++) begin
            checks++;
            if (emitted[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL filter_char[%0d]: got %0h expected %0h", i, emitted[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int  lvl;
        bit  p, pu, dr, to;
        emitted.delete();
        exp_q.delete();
        ovf_cnt = 0;
        lvl = 0;
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk25);
            if (k > 0) begin
                // Occupancy model: first pop one edge after the first write, then one per 6 cycles.
                p  = ((k - 1) % (2 + H + L) == 1) && (lvl > 0);
                pu = (lvl < 16) || p;
                dr = !pu;
                lvl = lvl + int'(pu) - int'(p);
                if (pu) expand(7'(32'h41 + k - 1));
                checks += 3;
                if (bus.fifo_level !== 5'(lvl)) begin
                    errors++;
                    $display("FAIL b2b_level@%0d: got %0d expected %0d", k - 1, bus.fifo_level, lvl);
                end
                if (bus.ready !== (lvl < 16)) begin
                    errors++;
                    $display("FAIL b2b_ready@%0d: got %b expected %b", k - 1, bus.ready, (lvl < 16));
                end
                if (bus.overflow !== dr) begin
                    errors++;
                    $display("FAIL b2b_ovf@%0d: got %b expected %b", k - 1, bus.overflow, dr);
                end
            end
            if (k < 24) begin
                bus.wr_data = 7'(32'h41 + k);
                bus.wr_stb  = 1'b1;
            end else begin
                bus.wr_stb = 1'b0;
            end
        end
        wait_emitted(exp_q.size(), to);
        checks += 4;
        if (to) begin errors++; $display("FAIL b2b_timeout: got %0d pulses expected %0d", emitted.size(), exp_q.size()); end
        if (exp_q.size() != 20) begin errors++; $display("FAIL b2b_model_count: got %0d expected 20", exp_q.size()); end
        if (emitted.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected %0d", emitted.size(), exp_q.size());
        end
        if (ovf_cnt != 4) begin errors++; $display("FAIL b2b_ovf_count: got %0d expected 4", ovf_cnt); end
        for (int i = 0; i < exp_q.size() && i < emitted.size(); i++) begin
            checks++;
            if (emitted[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_char[%0d]: got %0h expected %0h", i, emitted[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_cr();
        logic [6:0] seq[4];
        int first;
        bit to;
`ifdef VGA_CHAR_FEEDER_CR_PAD_EN
        seq = '{7'h41, 7'h42, 7'h0D, 7'h0D};
        do_reset();
`else
        seq = '{7'h41, 7'h0D, 7'h42, 7'h07};
        emitted.delete();
        exp_q.delete();
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk25);
            bus.wr_data = seq[i];
            bus.wr_stb  = 1'b1;
            expand(seq[i]);
        end
        @(negedge clk25);
        bus.wr_stb = 1'b0;
        wait_emitted(exp_q.size(), to);
        first = emitted.size();
        @(negedge clk25);
        bus.wr_data = seq[3];
        bus.wr_stb  = 1'b1;
        expand(seq[3]);
        @(negedge clk25);
        bus.wr_stb = 1'b0;
        wait_emitted(exp_q.size(), to);
        checks += 3;
        if (to) begin errors++; $display("FAIL cr_timeout: got %0d pulses expected %0d", emitted.size(), exp_q.size()); end
`ifdef VGA_CHAR_FEEDER_CR_PAD_EN
        if (first != 40) begin errors++; $display("FAIL cr_first_row: got %0d pulses expected 40", first); end
        if (emitted.size() != 80) begin errors++; $display("FAIL cr_blank_row: got %0d pulses expected 80", emitted.size()); end
`else
        if (first != 2) begin errors++; $display("FAIL cr_ignored: got %0d pulses expected 2", first); end
        if (emitted.size() != 2) begin errors++; $display("FAIL cr_total: got %0d pulses expected 2", emitted.size()); end
`endif
        for (int i = 0; i < exp_q.size() && i < emitted.size(); i++) begin
            checks++;
            if (emitted[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL cr_char[%0d]: got %0h expected %0h", i, emitted[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int len, start;
        logic [6:0] c;
        bit to;
        emitted.delete();
        exp_q.delete();
        ovf_cnt = 0;
        for (int b = 0; b < 6; b++) begin
            start = exp_q.size();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                @(negedge clk25);
                c = 7'($urandom_range(0, 127));
                bus.wr_data = c;
                bus.wr_stb  = 1'b1;
                expand(c);
            end
            @(negedge clk25);
            bus.wr_stb = 1'b0;
            wait_emitted(exp_q.size(), to);
            checks += 2;
            if (to) begin errors++; $display("FAIL rand_timeout: burst %0d got %0d expected %0d", b, emitted.size(), exp_q.size()); end
            if (emitted.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand_count: burst %0d got %0d expected %0d", b, emitted.size(), exp_q.size());
            end
            for (int i = start; i < exp_q.size() && i < emitted.size(); i++) begin
                checks++;
                if (emitted[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_char[%0d]: got %0h expected %0h", i, emitted[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (ovf_cnt != 0) begin errors++; $display("FAIL rand_ovf: got %0d expected 0", ovf_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_filter();
        test_back_to_back();
        test_cr();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
